// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, controller state encoding,
// the forward S-box and GF(2^8) doubling.
package aes_pkg;

    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aesState_t;

    // Entry for input byte b sits at bits [2047-8b -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb = 11'h7ff - {b, 3'b000};
        return SBOX_TABLE[msb -: 8];
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the current one.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rotWord;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_in;
    assign rotWord = {w3[23:0], w3[31:24]};

    assign temp = {sbox(rotWord[31:24]), sbox(rotWord[23:16]),
                   sbox(rotWord[15:8]),  sbox(rotWord[7:0])} ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/round_encryption.sv
// One full AES middle round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module round_encryption
    import aes_pkg::*;
(
    input  logic [127:0] stateIn,
    input  logic [127:0] roundKey,
    output logic [127:0] stateOut
);

    logic [127:0] subbed;
    logic [127:0] shifted;
    logic [127:0] mixed;

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    substitute_bytes uSub (
        .dataIn  (stateIn),
        .dataOut (subbed)
    );

    shift_rows uShift (
        .dataIn  (subbed),
        .dataOut (shifted)
    );

    for (genvar c = 0; c < 4; c++) begin : gMix
        assign mixed[127 - 32*c -: 32] = mixColumn(shifted[127 - 32*c -: 32]);
    end

    assign stateOut = mixed ^ roundKey;

endmodule

// File: rtl/shift_rows.sv
// ShiftRows on a column-major state (byte 4c+r is row r, column c; byte 0 at the MSB).
module shift_rows (
    input  logic [127:0] dataIn,
    output logic [127:0] dataOut
);

    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : gCol
        for (genvar r = 0; r < 4; r++) begin : gRow
            assign dataOut[127 - 8*(4*c + r) -: 8] = dataIn[127 - 8*(4*((c + r) % 4) + r) -: 8];
        end
    end

endmodule

// File: rtl/substitute_bytes.sv
// SubBytes: forward S-box applied independently to all 16 state bytes.
module substitute_bytes
    import aes_pkg::*;
(
    input  logic [127:0] dataIn,
    output logic [127:0] dataOut
);

    for (genvar i = 0; i < 16; i++) begin : gSbox
        assign dataOut[8*i +: 8] = sbox(dataIn[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one shared round datapath, on-the-fly
// key expansion and a valid/ready block interface.
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);

    aesState_t          curState;
    aesState_t          nextState;
    logic [127:0]       stateReg;
    logic [127:0]       rkReg;
    logic [127:0]       rkNext;
    logic [127:0]       roundOut;
    logic [127:0]       finalSub;
    logic [127:0]       finalShift;
    logic [7:0]         rcon;
    logic [CNT_W-1:0]   cnt;

    aes_key_step uKeyStep (
        .rk_in  (rkReg),
        .rcon   (rcon),
        .rk_out (rkNext)
    );

    round_encryption uRound (
        .stateIn  (stateReg),
        .roundKey (rkNext),
        .stateOut (roundOut)
    );

    // The last round skips MixColumns, so it gets its own SubBytes/ShiftRows pair.
    substitute_bytes uFinalSub (
        .dataIn  (stateReg),
        .dataOut (finalSub)
    );

    shift_rows uFinalShift (
        .dataIn  (finalSub),
        .dataOut (finalShift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (curState)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nextState = ROUND;
                end
            end
            ROUND: begin
                if (cnt == CNT_W'(NR - 1)) begin
                    nextState = FINAL;
                end
            end
            FINAL: begin
                nextState = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Inputs are copied on the accept edge only; rcon restarts per block so a
    // previous (or aborted) block cannot leak its schedule position.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= '0;
            rkReg      <= '0;
            rcon       <= RCON_INIT;
            cnt        <= '0;
            ciphertext <= '0;
        end else begin
            case (curState)
                IDLE: begin
                    if (in_valid) begin
                        stateReg <= plaintext ^ key;
                        rkReg    <= key;
                        rcon     <= RCON_INIT;
                        cnt      <= CNT_W'(1);
                    end
                end
                ROUND: begin
                    stateReg <= roundOut;
                    rkReg    <= rkNext;
                    rcon     <= xtime(rcon);
                    cnt      <= cnt + 1'b1;
                end
                FINAL: begin
                    ciphertext <= finalShift ^ rkNext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 known-answer vectors,
// backpressure, ignored inputs while busy and mid-block reset.
module tb_aes128_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    // Accept cycle plus ten further cycles until out_valid is seen.
    localparam int           LATENCY = 11;
    localparam int           WAIT_LIMIT = 40;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    int           assertCount = 0;
    int           failCount = 0;
    int           cycles;
    int           badCycles;
    logic [127:0] rkSeen;
    logic [127:0] ctHeld;

    aes128_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Offers one block for a single accept edge, then corrupts the inputs.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k, input bit holdValid);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        tick();
        in_valid  = holdValid;
        plaintext = ~pt;
        key       = ~k;
    endtask

    // Waits (bounded) for out_valid; optionally keeps offering junk blocks meanwhile.
    task automatic waitResult(input bit scramble, output int cyc, output logic [127:0] rk10);
        cyc  = 1;
        rk10 = '0;
        while (out_valid !== 1'b1 && cyc < WAIT_LIMIT) begin
            if (scramble) begin
                in_valid  = 1'b1;
                plaintext = {$urandom, $urandom, $urandom, $urandom};
                key       = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            cyc++;
            if (dut.curState == FINAL) begin
                rk10 = dut.rkNext;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic completeHandshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        tick();
        tick();
        checkOutput("resetInReady", in_ready, 1);
        checkOutput("resetOutValid", out_valid, 0);
        checkOutput("resetCiphertext", ciphertext, 0);
        rst = 1'b0;

        // FIPS-197 Appendix B, with latency and round-10 key trace.
        applyStimulus(PT_B, KEY_B, 1'b0);
        checkOutput("busyAfterAccept", in_ready, 0);
        waitResult(1'b0, cycles, rkSeen);
        checkOutput("latencyB", cycles, LATENCY);
        checkOutput("round10KeyB", rkSeen, RK10_B);
        checkOutput("ctB", ciphertext, CT_B);
        completeHandshake();
        checkOutput("readyAfterB", in_ready, 1);
        checkOutput("validDropAfterB", out_valid, 0);

        // FIPS-197 Appendix C.1, straight after the first block.
        applyStimulus(PT_C, KEY_C, 1'b0);
        waitResult(1'b0, cycles, rkSeen);
        checkOutput("latencyC", cycles, LATENCY);
        checkOutput("ctC", ciphertext, CT_C);
        completeHandshake();
        checkOutput("readyAfterC", in_ready, 1);

        // Backpressure: result must hold for 20 cycles with no new acceptance.
        applyStimulus(PT_B, KEY_B, 1'b0);
        waitResult(1'b0, cycles, rkSeen);
        ctHeld = ciphertext;
        checkOutput("ctBeforeStall", ctHeld, CT_B);
        badCycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || ciphertext !== ctHeld || in_ready !== 1'b0) begin
                badCycles++;
            end
        end
        checkOutput("stallStable", badCycles, 0);

        // in_valid together with out_ready in DONE: only the output handshake happens.
        plaintext = PT_C;
        key       = KEY_C;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("idleAfterStall", in_ready, 1);
        checkOutput("validAfterStall", out_valid, 0);
        tick();
        in_valid  = 1'b0;
        plaintext = '0;
        key       = '0;
        checkOutput("acceptInIdle", in_ready, 0);
        waitResult(1'b0, cycles, rkSeen);
        checkOutput("ctChained", ciphertext, CT_C);
        completeHandshake();

        // in_valid held with changing data during rounds is ignored.
        applyStimulus(PT_B, KEY_B, 1'b1);
        waitResult(1'b1, cycles, rkSeen);
        checkOutput("latencyNoisy", cycles, LATENCY);
        checkOutput("ctNoisy", ciphertext, CT_B);
        completeHandshake();
        checkOutput("readyAfterNoisy", in_ready, 1);

        // Reset during round 5 discards the block and leaves no stale schedule.
        applyStimulus(PT_C, KEY_C, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midResetInReady", in_ready, 1);
        checkOutput("midResetOutValid", out_valid, 0);
        checkOutput("midResetCiphertext", ciphertext, 0);
        badCycles = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) begin
                badCycles++;
            end
        end
        checkOutput("noValidAfterReset", badCycles, 0);
        applyStimulus(PT_B, KEY_B, 1'b0);
        waitResult(1'b0, cycles, rkSeen);
        checkOutput("latencyAfterReset", cycles, LATENCY);
        checkOutput("round10KeyAfterReset", rkSeen, RK10_B);
        checkOutput("ctAfterReset", ciphertext, CT_B);
        completeHandshake();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
